// File: rtl/operand_fetch_stage.sv
// Decode / operand-fetch stage: register read with write-back bypass,
// x0 forcing, destination scoreboard for RAW/WAW stalls, valid/ready to EX.
module operand_fetch_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_instr_valid,
   input  logic [31:0]           i_instr,
   input  logic [XLEN-1:0]       i_pc,
   output logic                  o_instr_ready,
   output logic [REG_ADDR_W-1:0] o_rf_reg_num_1,
   output logic [REG_ADDR_W-1:0] o_rf_reg_num_2,
   input  logic [XLEN-1:0]       i_rf_rs_1,
   input  logic [XLEN-1:0]       i_rf_rs_2,
   input  logic                  i_wb_valid,
   input  logic [REG_ADDR_W-1:0] i_wb_reg_num,
   input  logic [XLEN-1:0]       i_wb_val,
   input  logic                  i_flush,
   output logic                  o_ex_valid,
   input  logic                  i_ex_ready,
   output logic [XLEN-1:0]       o_ex_pc,
   output logic [31:0]           o_ex_instr,
   output logic [XLEN-1:0]       o_ex_rs_1,
   output logic [XLEN-1:0]       o_ex_rs_2,
   output logic [REG_ADDR_W-1:0] o_ex_rd
);

   localparam int NREG = 1 << REG_ADDR_W;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   logic [6:0]            opcode;
   logic                  use_rs1;
   logic                  use_rs2;
   logic                  use_rd;
   logic [REG_ADDR_W-1:0] rs1_idx;
   logic [REG_ADDR_W-1:0] rs2_idx;
   logic [REG_ADDR_W-1:0] rd_idx;
   logic [NREG-1:0]       busy;
   logic [NREG-1:0]       busy_next;
   logic                  hazard;
   logic                  issue;
   logic                  accept;
   logic [XLEN-1:0]       op1;
   logic [XLEN-1:0]       op2;

   // A register is blocked while an older instruction still owes it a
   // result: either scoreboarded (and not being written right now) or
   // sitting in our own stage register.
   function automatic logic pending(
      input logic [REG_ADDR_W-1:0] r,
      input logic [NREG-1:0]       bsy,
      input logic                  wbv,
      input logic [REG_ADDR_W-1:0] wbr,
      input logic                  exv,
      input logic [REG_ADDR_W-1:0] exrd
   );
      logic wb_hit;
      wb_hit = wbv && (wbr == r);
      return (r != '0) &&
             ((bsy[r] && !wb_hit) || (exv && (exrd == r)));
   endfunction

   // x0 reads as zero; a same-cycle write-back overrides the RF port.
   function automatic logic [XLEN-1:0] sel_operand(
      input logic [REG_ADDR_W-1:0] idx,
      input logic [XLEN-1:0]       rf_val,
      input logic                  wbv,
      input logic [REG_ADDR_W-1:0] wbr,
      input logic [XLEN-1:0]       wbval
   );
      logic [XLEN-1:0] v;
      if (idx == '0)
         v = '0;
      else if (wbv && (wbr == idx))
         v = wbval;
      else
         v = rf_val;
      return v;
   endfunction

   assign opcode         = i_instr[6:0];
   assign o_rf_reg_num_1 = i_instr[19:15];
   assign o_rf_reg_num_2 = i_instr[24:20];

   // Per-opcode source/destination usage
   always_comb begin
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      use_rd  = 1'b1;
      unique case (1'b1)
         (opcode == OPC_LUI),
         (opcode == OPC_AUIPC),
         (opcode == OPC_JAL): use_rs1 = 1'b0;
         (opcode == OPC_OP): use_rs2 = 1'b1;
         (opcode == OPC_STORE),
         (opcode == OPC_BRANCH): begin
            use_rs2 = 1'b1;
            use_rd  = 1'b0;
         end
         default: ;
      endcase
   end

   assign rs1_idx = use_rs1 ? i_instr[19:15] : '0;
   assign rs2_idx = use_rs2 ? i_instr[24:20] : '0;
   assign rd_idx  = use_rd  ? i_instr[11:7]  : '0;

   assign op1 = sel_operand(rs1_idx, i_rf_rs_1,
                            i_wb_valid, i_wb_reg_num, i_wb_val);
   assign op2 = sel_operand(rs2_idx, i_rf_rs_2,
                            i_wb_valid, i_wb_reg_num, i_wb_val);

   // Hazard check for the presented instruction
   always_comb begin
      hazard = 1'b0;
      if (i_instr_valid) begin
         hazard =
            pending(rs1_idx, busy, i_wb_valid, i_wb_reg_num,
                    o_ex_valid, o_ex_rd) ||
            pending(rs2_idx, busy, i_wb_valid, i_wb_reg_num,
                    o_ex_valid, o_ex_rd) ||
            pending(rd_idx, busy, i_wb_valid, i_wb_reg_num,
                    o_ex_valid, o_ex_rd);
      end
   end

   assign issue         = o_ex_valid && i_ex_ready;
   assign o_instr_ready = (!o_ex_valid || i_ex_ready) &&
                          !hazard && !i_flush;
   assign accept        = i_instr_valid && o_instr_ready;

   // Scoreboard update: clear on write-back, then set on issue so a
   // same-register set/clear in one cycle leaves the bit set.
   always_comb begin
      busy_next = busy;
      if (i_wb_valid)
         busy_next[i_wb_reg_num] = 1'b0;
      if (issue)
         busy_next[o_ex_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // Scoreboard register, wiped by flush
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         busy <= '0;
      else if (i_flush)
         busy <= '0;
      else
         busy <= busy_next;
   end

   // Stage register toward EX; payload holds during stalls
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ex_valid <= 1'b0;
         o_ex_pc    <= '0;
         o_ex_instr <= '0;
         o_ex_rs_1  <= '0;
         o_ex_rs_2  <= '0;
         o_ex_rd    <= '0;
      end else if (i_flush) begin
         o_ex_valid <= 1'b0;
      end else if (accept) begin
         o_ex_valid <= 1'b1;
         o_ex_pc    <= i_pc;
         o_ex_instr <= i_instr;
         o_ex_rs_1  <= op1;
         o_ex_rs_2  <= op2;
         o_ex_rd    <= rd_idx;
      end else if (issue) begin
         o_ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Randomized bench for operand_fetch_stage against a behavioural model
// of the scoreboard, bypass and handshake rules.
module tb_operand_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_ready;
   logic [4:0]  rf_num_1;
   logic [4:0]  rf_num_2;
   logic [31:0] rf_rs_1;
   logic [31:0] rf_rs_2;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic [31:0] wb_val;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_instr;
   logic [31:0] ex_rs_1;
   logic [31:0] ex_rs_2;
   logic [4:0]  ex_rd;

   int n_vec = 0;
   int n_bad = 0;

   logic [31:0] rf [32];

   bit          busy_m [32];
   bit          m_valid;
   logic [31:0] m_pc;
   logic [31:0] m_ins;
   logic [31:0] m_rs1;
   logic [31:0] m_rs2;
   logic [4:0]  m_rd;

   always #5 clk = ~clk;

   assign rf_rs_1 = rf[instr[19:15]];
   assign rf_rs_2 = rf[instr[24:20]];

   operand_fetch_stage dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_instr_valid  (instr_valid),
      .i_instr        (instr),
      .i_pc           (pc),
      .o_instr_ready  (instr_ready),
      .o_rf_reg_num_1 (rf_num_1),
      .o_rf_reg_num_2 (rf_num_2),
      .i_rf_rs_1      (rf_rs_1),
      .i_rf_rs_2      (rf_rs_2),
      .i_wb_valid     (wb_valid),
      .i_wb_reg_num   (wb_reg),
      .i_wb_val       (wb_val),
      .i_flush        (flush),
      .o_ex_valid     (ex_valid),
      .i_ex_ready     (ex_ready),
      .o_ex_pc        (ex_pc),
      .o_ex_instr     (ex_instr),
      .o_ex_rs_1      (ex_rs_1),
      .o_ex_rs_2      (ex_rs_2),
      .o_ex_rd        (ex_rd)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   function automatic bit reads_rs1(input logic [31:0] ins);
      return !(ins[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
   endfunction

   function automatic bit reads_rs2(input logic [31:0] ins);
      return ins[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
   endfunction

   function automatic bit writes_rd(input logic [31:0] ins);
      return !(ins[6:0] inside {7'b0100011, 7'b1100011});
   endfunction

   function automatic bit blocked(input logic [4:0] r, input bit wbv,
                                  input logic [4:0] wbr);
      if (r == 0) return 0;
      if (busy_m[r] && !(wbv && wbr == r)) return 1;
      if (m_valid && m_rd == r) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] r,
      input bit wbv, input logic [4:0] wbr, input logic [31:0] wbd);
      if (r == 0) return 32'd0;
      if (wbv && wbr == r) return wbd;
      return rf[r];
   endfunction

   function automatic logic [31:0] r_type(input int rd, input int a,
                                          input int b);
      return {7'd0, 5'(b), 5'(a), 3'd0, 5'(rd), 7'b0110011};
   endfunction

   function automatic logic [31:0] i_type(input int rd, input int a,
                                          input int imm);
      return {12'(imm), 5'(a), 3'd0, 5'(rd), 7'b0010011};
   endfunction

   task automatic model_reset();
      foreach (busy_m[i]) busy_m[i] = 0;
      m_valid = 0;
      m_pc = '0; m_ins = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
   endtask

   // One clock: drive at negedge, check, advance model across posedge.
   task automatic step(input bit iv, input logic [31:0] ins,
                       input logic [31:0] p, input bit exr,
                       input bit wbv, input logic [4:0] wbr,
                       input logic [31:0] wbd, input bit fl);
      logic [4:0]  s1, s2, d;
      bit          rdy, iss;
      bit          nb [32];
      instr_valid = iv; instr = ins; pc = p; ex_ready = exr;
      wb_valid = wbv; wb_reg = wbr; wb_val = wbd; flush = fl;
      #1;
      s1 = reads_rs1(ins) ? ins[19:15] : 5'd0;
      s2 = reads_rs2(ins) ? ins[24:20] : 5'd0;
      d  = writes_rd(ins) ? ins[11:7]  : 5'd0;
      rdy = (!m_valid || exr) && !fl &&
            !(iv && (blocked(s1, wbv, wbr) || blocked(s2, wbv, wbr) ||
                     blocked(d, wbv, wbr)));
      chk("ready", instr_ready, rdy);
      chk("rf_num_1", rf_num_1, ins[19:15]);
      chk("rf_num_2", rf_num_2, ins[24:20]);
      chk("ex_valid", ex_valid, m_valid);
      if (m_valid) begin
         chk("ex_pc", ex_pc, m_pc);
         chk("ex_instr", ex_instr, m_ins);
         chk("ex_rs_1", ex_rs_1, m_rs1);
         chk("ex_rs_2", ex_rs_2, m_rs2);
         chk("ex_rd", ex_rd, m_rd);
      end
      iss = m_valid && exr;
      nb = busy_m;
      if (wbv && wbr != 0) nb[wbr] = 0;
      if (iss && m_rd != 0) nb[m_rd] = 1;
      @(posedge clk);
      #1;
      if (fl) begin
         foreach (busy_m[i]) busy_m[i] = 0;
         m_valid = 0;
      end else begin
         busy_m = nb;
         if (iv && rdy) begin
            m_valid = 1;
            m_pc = p; m_ins = ins; m_rd = d;
            m_rs1 = operand(s1, wbv, wbr, wbd);
            m_rs2 = operand(s2, wbv, wbr, wbd);
         end else if (iss) begin
            m_valid = 0;
         end
      end
      if (wbv && wbr != 0) rf[wbr] = wbd;
      @(negedge clk);
   endtask

   task automatic idle(input bit exr);
      step(0, 32'h13, 32'h0, exr, 0, 5'd0, 32'h0, 0);
   endtask

   task automatic drain();
      idle(1);
      for (int r = 1; r < 32; r++)
         if (busy_m[r])
            step(0, 32'h13, 32'h0, 1, 1, 5'(r), $urandom, 0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [9];
      logic [31:0] w;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
              7'b1100111};
      w = $urandom;
      w[6:0]   = ops[$urandom_range(0, 8)];
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      return w;
   endfunction

   initial begin
      int         q [$];
      logic [4:0] wr;
      bit         wv;
      foreach (rf[i]) rf[i] = $urandom;
      rf[0] = 32'hBAD0_BAD0;
      rst_n = 1'b0;
      instr_valid = 0; instr = 32'h13; pc = 0; ex_ready = 0;
      wb_valid = 0; wb_reg = 0; wb_val = 0; flush = 0;
      model_reset();
      @(negedge clk);
      chk("rst_valid", ex_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // reset in the middle of a stall
      step(1, i_type(1, 0, 5), 32'h100, 0, 0, 5'd0, 32'h0, 0);
      step(1, r_type(2, 3, 4), 32'h104, 0, 0, 5'd0, 32'h0, 0);
      chk("pre_rst_valid", ex_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_valid", ex_valid, 0);
      chk("rst_async_pc", ex_pc, 0);
      chk("rst_async_instr", ex_instr, 0);
      chk("rst_async_rs", ex_rs_1 | ex_rs_2, 0);
      chk("rst_async_rd", ex_rd, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // back-to-back stream
      step(1, i_type(1, 0, 5), 32'h200, 1, 0, 5'd0, 32'h0, 0);
      step(1, r_type(2, 3, 4), 32'h204, 1, 0, 5'd0, 32'h0, 0);
      chk("stream_pc", ex_pc, 32'h204);
      drain();

      // RAW on x1 until its write-back
      step(1, i_type(1, 0, 5), 32'h300, 1, 0, 5'd0, 32'h0, 0);
      step(1, r_type(2, 1, 1), 32'h304, 1, 0, 5'd0, 32'h0, 0);
      step(1, r_type(2, 1, 1), 32'h304, 1, 0, 5'd0, 32'h0, 0);
      step(1, r_type(2, 1, 1), 32'h304, 1, 1, 5'd1, 32'd5, 0);
      chk("raw_rs_1", ex_rs_1, 5);
      chk("raw_rs_2", ex_rs_2, 5);
      drain();

      // x0 write-back neither bypasses nor stalls
      step(1, r_type(5, 0, 0), 32'h400, 1, 1, 5'd0, 32'hDEAD, 0);
      chk("x0_rs", ex_rs_1 | ex_rs_2, 0);
      drain();

      // backpressure
      step(1, r_type(6, 2, 3), 32'h500, 0, 0, 5'd0, 32'h0, 0);
      for (int i = 0; i < 3; i++)
         step(1, r_type(7, 4, 5), 32'h504, 0, 0, 5'd0, 32'h0, 0);
      chk("bp_hold_pc", ex_pc, 32'h500);
      step(1, r_type(7, 4, 5), 32'h504, 1, 0, 5'd0, 32'h0, 0);
      step(1, r_type(7, 4, 5), 32'h504, 1, 0, 5'd0, 32'h0, 0);
      chk("bp_resume_pc", ex_pc, 32'h504);
      drain();

      // flush kills stage and scoreboard
      step(1, i_type(1, 0, 5), 32'h600, 1, 0, 5'd0, 32'h0, 0);
      step(1, i_type(3, 0, 7), 32'h604, 0, 0, 5'd0, 32'h0, 0);
      step(1, r_type(2, 1, 1), 32'h608, 0, 0, 5'd0, 32'h0, 1);
      step(1, r_type(2, 1, 1), 32'h608, 0, 0, 5'd0, 32'h0, 0);
      chk("flush_accept_pc", ex_pc, 32'h608);
      drain();

      // random traffic
      for (int c = 0; c < 600; c++) begin
         q.delete();
         for (int r = 1; r < 32; r++) if (busy_m[r]) q.push_back(r);
         wv = 0; wr = 0;
         if (q.size() > 0 && $urandom_range(0, 9) < 6) begin
            wv = 1;
            wr = 5'(q[$urandom_range(0, q.size() - 1)]);
         end else if ($urandom_range(0, 9) < 2) begin
            wv = 1;
            wr = 5'($urandom_range(0, 7));
         end
         step($urandom_range(0, 9) < 8, rand_instr(), $urandom,
              $urandom_range(0, 9) < 7, wv, wr, $urandom,
              $urandom_range(0, 99) < 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
